// File: rtl/reqrsp_xbar_rsp_tracker.sv
// Per-bank response routing tracker: remembers which requester issued each accepted
// request that expects a response, and steers bank responses back to it in order.
module reqrsp_xbar_rsp_tracker #(
    parameter int unsigned NumInp         = 4,
    parameter int unsigned NumOut         = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              clr_i,
    input  logic [NumOut-1:0]                                 xbar_req_valid_i,
    output logic [NumOut-1:0]                                 xbar_req_ready_o,
    input  logic [NumOut-1:0][$clog2(NumInp)-1:0]             xbar_req_src_i,
    input  logic [NumOut-1:0]                                 xbar_req_rsp_exp_i,
    output logic [NumOut-1:0]                                 bank_req_valid_o,
    input  logic [NumOut-1:0]                                 bank_req_ready_i,
    input  logic [NumOut-1:0]                                 bank_rsp_valid_i,
    output logic [NumOut-1:0]                                 bank_rsp_ready_o,
    output logic [NumOut-1:0]                                 xbar_rsp_valid_o,
    input  logic [NumOut-1:0]                                 xbar_rsp_ready_i,
    output logic [NumOut-1:0][$clog2(NumInp)-1:0]             xbar_rsp_sel_o,
    output logic [NumOut-1:0][$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                              idle_o,
    output logic [NumOut-1:0]                                 err_o
);

    localparam int unsigned SelW = $clog2(NumInp);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);

    typedef logic [SelW-1:0] mst_sel_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

    logic [NumOut-1:0] bank_idle;

    assign idle_o = &bank_idle;

    for (genvar o = 0; o < NumOut; o++) begin : g_bank
        mst_sel_t mem [MaxOutstanding];
        ptr_t     wr_ptr;
        ptr_t     rd_ptr;
        cnt_t     cnt;
        logic     full;
        logic     empty;
        logic     push;
        logic     pop;
        logic     err;

        assign full  = (cnt == CntMax);
        assign empty = (cnt == '0);

        // Request side only looks at full, so response traffic never reaches request ready.
        assign bank_req_valid_o[o] = xbar_req_valid_i[o] & ~full;
        assign xbar_req_ready_o[o] = bank_req_ready_i[o] & ~full;
        assign push = xbar_req_valid_i[o] & bank_req_ready_i[o] & ~full & xbar_req_rsp_exp_i[o];

        assign xbar_rsp_valid_o[o] = bank_rsp_valid_i[o] & ~empty;
        assign bank_rsp_ready_o[o] = xbar_rsp_ready_i[o] & ~empty;
        assign pop = bank_rsp_valid_i[o] & xbar_rsp_ready_i[o] & ~empty;

        assign xbar_rsp_sel_o[o] = empty ? mst_sel_t'('0) : mem[rd_ptr];
        assign outstanding_o[o]  = cnt;
        assign err_o[o]          = err;
        assign bank_idle[o]      = empty;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int i = 0; i < int'(MaxOutstanding); i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr] <= xbar_req_src_i[o];
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt <= '0;
            end else begin
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // A new unmatched response takes priority over a clear in the same cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                err <= 1'b0;
            end else if (bank_rsp_valid_i[o] & empty) begin
                err <= 1'b1;
            end else if (clr_i) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reqrsp_xbar_rsp_tracker.sv
// Directed bench for reqrsp_xbar_rsp_tracker: in-order routing, full/empty gating,
// error flag behaviour and asynchronous reset.
module tb_reqrsp_xbar_rsp_tracker;

    localparam int NumInp = 4;
    localparam int NumOut = 4;
    localparam int MaxOut = 4;

    logic                   clk;
    logic                   rstN;
    logic                   clr;
    logic [NumOut-1:0]      reqValid;
    logic [NumOut-1:0]      reqReady;
    logic [NumOut-1:0][1:0] reqSrc;
    logic [NumOut-1:0]      rspExp;
    logic [NumOut-1:0]      bankReqValid;
    logic [NumOut-1:0]      bankReqReady;
    logic [NumOut-1:0]      bankRspValid;
    logic [NumOut-1:0]      bankRspReady;
    logic [NumOut-1:0]      xbarRspValid;
    logic [NumOut-1:0]      xbarRspReady;
    logic [NumOut-1:0][1:0] rspSel;
    logic [NumOut-1:0][2:0] outstanding;
    logic                   idle;
    logic [NumOut-1:0]      err;

    int vectorCount = 0;
    int missCount   = 0;

    reqrsp_xbar_rsp_tracker #(
        .NumInp(NumInp),
        .NumOut(NumOut),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .clr_i(clr),
        .xbar_req_valid_i(reqValid),
        .xbar_req_ready_o(reqReady),
        .xbar_req_src_i(reqSrc),
        .xbar_req_rsp_exp_i(rspExp),
        .bank_req_valid_o(bankReqValid),
        .bank_req_ready_i(bankReqReady),
        .bank_rsp_valid_i(bankRspValid),
        .bank_rsp_ready_o(bankRspReady),
        .xbar_rsp_valid_o(xbarRspValid),
        .xbar_rsp_ready_i(xbarRspReady),
        .xbar_rsp_sel_o(rspSel),
        .outstanding_o(outstanding),
        .idle_o(idle),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idleInputs();
        reqValid     = '0;
        reqSrc       = '0;
        rspExp       = '0;
        bankReqReady = '1;
        bankRspValid = '0;
        xbarRspReady = '1;
        clr          = 1'b0;
    endtask

    initial begin
        logic [1:0] srcList [4];
        idleInputs();
        rstN = 1'b0;
        #12;
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_cnt", outstanding, 0);
        checkOutput("rst_req_ready", reqReady, 4'hF);
        checkOutput("rst_rsp_ready", bankRspReady, 0);
        rstN = 1'b1;
        applyStimulus();

        // Bank 0: three requests, three in-order responses
        srcList = '{2'd2, 2'd0, 2'd3, 2'd0};
        reqValid[0] = 1'b1;
        rspExp[0]   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqSrc[0] = srcList[i];
            settle();
            checkOutput("b0_req_valid", bankReqValid[0], 1);
            applyStimulus();
            checkOutput("b0_cnt_up", outstanding[0], i + 1);
            checkOutput("b0_head", rspSel[0], 2);
        end
        idleInputs();
        bankRspValid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput("b0_sel", rspSel[0], srcList[i]);
            checkOutput("b0_rsp_valid", xbarRspValid[0], 1);
            applyStimulus();
            checkOutput("b0_cnt_down", outstanding[0], 2 - i);
        end
        checkOutput("b0_idle", idle, 1);
        checkOutput("b0_sel_empty", rspSel[0], 0);
        checkOutput("b0_no_err", err[0], 0);

        // Posted request on bank 0 passes without tracking
        idleInputs();
        reqValid[0] = 1'b1;
        reqSrc[0]   = 2'd1;
        settle();
        checkOutput("posted_fwd", bankReqValid[0], 1);
        applyStimulus();
        checkOutput("posted_cnt", outstanding[0], 0);
        checkOutput("posted_idle", idle, 1);

        // Bank 1: fill to four, fifth request blocked until a pop
        idleInputs();
        srcList = '{2'd0, 2'd1, 2'd2, 2'd3};
        reqValid[1] = 1'b1;
        rspExp[1]   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reqSrc[1] = srcList[i];
            applyStimulus();
        end
        reqSrc[1] = 2'd2;
        settle();
        checkOutput("b1_full_cnt", outstanding[1], 4);
        checkOutput("b1_full_ready", reqReady[1], 0);
        checkOutput("b1_full_valid", bankReqValid[1], 0);
        applyStimulus();
        checkOutput("b1_still_full", outstanding[1], 4);
        bankRspValid[1] = 1'b1;
        settle();
        checkOutput("b1_pop_sel", rspSel[1], 0);
        checkOutput("b1_pop_ready_blk", reqReady[1], 0);
        applyStimulus();
        checkOutput("b1_after_pop", outstanding[1], 3);
        bankRspValid[1] = 1'b0;
        settle();
        checkOutput("b1_fifth_ready", reqReady[1], 1);
        applyStimulus();
        checkOutput("b1_fifth_cnt", outstanding[1], 4);
        reqValid[1] = 1'b0;
        bankRspValid[1] = 1'b1;
        srcList = '{2'd1, 2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("b1_drain_sel", rspSel[1], srcList[i]);
            applyStimulus();
        end
        checkOutput("b1_drained", outstanding[1], 0);
        bankRspValid[1] = 1'b0;

        // Bank 2: full with simultaneous request and response
        idleInputs();
        reqValid[2] = 1'b1;
        rspExp[2]   = 1'b1;
        reqSrc[2]   = 2'd3;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("b2_full", outstanding[2], 4);
        bankRspValid[2] = 1'b1;
        settle();
        checkOutput("b2_both_ready", reqReady[2], 0);
        checkOutput("b2_both_rsp", xbarRspValid[2], 1);
        applyStimulus();
        checkOutput("b2_pop_only", outstanding[2], 3);
        bankRspValid[2] = 1'b0;
        applyStimulus();
        checkOutput("b2_push_after", outstanding[2], 4);

        // Bank 3: unmatched response, sticky error, clear and set-wins
        idleInputs();
        bankRspValid[3] = 1'b1;
        settle();
        checkOutput("b3_rsp_ready", bankRspReady[3], 0);
        checkOutput("b3_rsp_valid", xbarRspValid[3], 0);
        checkOutput("b3_err_pre", err[3], 0);
        applyStimulus();
        checkOutput("b3_err_set", err[3], 1);
        bankRspValid[3] = 1'b0;
        applyStimulus();
        checkOutput("b3_err_held", err[3], 1);
        clr = 1'b1;
        applyStimulus();
        checkOutput("b3_err_clr", err[3], 0);
        bankRspValid[3] = 1'b1;
        applyStimulus();
        checkOutput("b3_set_wins", err[3], 1);
        idleInputs();

        // Bank 1: two outstanding, asynchronous reset mid-cycle
        reqValid[1] = 1'b1;
        rspExp[1]   = 1'b1;
        reqSrc[1]   = 2'd1;
        applyStimulus();
        applyStimulus();
        reqValid[1] = 1'b0;
        settle();
        checkOutput("rst_pre_cnt", outstanding[1], 2);
        rstN = 1'b0;
        #1;
        checkOutput("arst_cnt", outstanding[1], 0);
        checkOutput("arst_idle", idle, 1);
        checkOutput("arst_err", err, 0);
        applyStimulus();
        #3;
        rstN = 1'b1;
        applyStimulus();
        bankRspValid[1] = 1'b1;
        settle();
        checkOutput("late_rsp_valid", xbarRspValid[1], 0);
        applyStimulus();
        checkOutput("late_rsp_err", err[1], 1);
        idleInputs();
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
